// File: rtl/plab5_mcore_net_msg_to_mem_msg_q.sv
// Network-to-memory receive adapter: strips the network header, restores the
// memory opaque field for responses, and buffers results in a 2-entry queue.
module plab5_mcore_net_msg_to_mem_msg_q #(
    parameter int p_net_dest          = 0,
    parameter int p_is_resp           = 0,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    localparam int len_nbits = $clog2(p_mem_data_nbits / 8),
    localparam int mn = (p_is_resp != 0)
        ? (3 + p_mem_opaque_nbits + len_nbits + p_mem_data_nbits)
        : (3 + p_mem_opaque_nbits + p_mem_addr_nbits + len_nbits + p_mem_data_nbits),
    localparam int nn = mn + p_net_opaque_nbits + 2 * p_net_srcdest_nbits
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sd,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [nn-1:0] in_msg,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [mn-1:0] out_msg,
    output logic          misroute,
    output logic [7:0]    misroute_count,
    output logic [15:0]   msg_count
);

    localparam int mo = p_mem_opaque_nbits;
    localparam int md = p_mem_data_nbits;
    localparam int no = p_net_opaque_nbits;
    localparam int ns = p_net_srcdest_nbits;
    localparam logic [ns-1:0] dest_id = ns'(p_net_dest);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          enq_ptr_reg, enq_ptr_next;
    logic          deq_ptr_reg, deq_ptr_next;
    logic          misroute_reg;
    logic [7:0]    misroute_count_reg;
    logic [15:0]   msg_count_reg;
    logic          enq, deq, misroute_hit;
    logic [mn-1:0] enq_msg;
    logic [ns-1:0] dest_field;
    logic          unused_bits;

    assign in_rdy  = (state_reg != FULL);
    assign out_val = (state_reg != EMPTY);
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;

    assign dest_field   = in_msg[nn-1 -: ns];
    assign misroute_hit = enq && (dest_field != dest_id);

    // Network src and opaque fields are dropped; sd only labels the ports.
    assign unused_bits = ^{sd, in_msg[mn +: no + ns]};

    generate
        if (p_is_resp != 0) begin : g_resp
            localparam int op_lsb = md + len_nbits;
            logic unused_core_id;
            // Top ns opaque bits held the core id for network routing; the core
            // expects them cleared, so only the low mo-ns bits survive.
            assign enq_msg = {in_msg[mn-1 -: 3], {ns{1'b0}},
                              in_msg[op_lsb +: mo - ns], in_msg[op_lsb-1:0]};
            assign unused_core_id = ^in_msg[op_lsb + mo - ns +: ns];
        end else begin : g_req
            assign enq_msg = in_msg[mn-1:0];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [mn-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (enq && (enq_ptr_reg == 1'(gi))) begin
                    data_reg <= enq_msg;
                end
            end
        end
    endgenerate

    assign out_msg = deq_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

    always_comb begin
        state_next   = state_reg;
        enq_ptr_next = enq_ptr_reg;
        deq_ptr_next = deq_ptr_reg;
        if (enq) begin
            enq_ptr_next = ~enq_ptr_reg;
        end
        if (deq) begin
            deq_ptr_next = ~deq_ptr_reg;
        end
        case (state_reg)
            EMPTY:   if (enq) state_next = ONE;
            ONE: begin
                if (enq && !deq) begin
                    state_next = FULL;
                end else if (!enq && deq) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (deq) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= EMPTY;
            enq_ptr_reg        <= 1'b0;
            deq_ptr_reg        <= 1'b0;
            misroute_reg       <= 1'b0;
            misroute_count_reg <= 8'd0;
            msg_count_reg      <= 16'd0;
        end else begin
            state_reg   <= state_next;
            enq_ptr_reg <= enq_ptr_next;
            deq_ptr_reg <= deq_ptr_next;
            if (misroute_hit) begin
                misroute_reg <= 1'b1;
                if (misroute_count_reg != 8'hFF) begin
                    misroute_count_reg <= misroute_count_reg + 8'd1;
                end
            end
            if (deq) begin
                msg_count_reg <= msg_count_reg + 16'd1;
            end
        end
    end

    assign misroute       = misroute_reg;
    assign misroute_count = misroute_count_reg;
    assign msg_count      = msg_count_reg;

endmodule

// File: doc/plab5_mcore_net_msg_to_mem_msg_q.md
# plab5_mcore_net_msg_to_mem_msg_q

Receive-side network-to-memory adapter with a 2-entry elastic buffer. It accepts network messages from a router terminal, unpacks the payload into a memory request (bank side) or memory response (core side), and restores the opaque field for responses. It presents the result on a val/rdy memory port. It sits between the network terminal output and the cache bank request input or the core response input, and provides the inverse of the memory-to-network packing adapters.

## Interface
- p_net_dest, 0: terminal index of this port; incoming dest is checked against it.
- p_is_resp, 0: 0 = payload is a memory request (bank side); 1 = payload is a memory response (core side).
- p_mem_opaque_nbits (mo), 8: memory opaque width.
- p_mem_addr_nbits (ma), 32: address width; used only when p_is_resp=0.
- p_mem_data_nbits (md), 32: data width.
- p_net_opaque_nbits (no), 4: network opaque width.
- p_net_srcdest_nbits (ns), 3: network src/dest width; must satisfy ns < mo.
- Derived values:
  - mem msg width mn = `VC_MEM_REQ_MSG_NBITS(mo,ma,md)` or `VC_MEM_RESP_MSG_NBITS(mo,md)`.
  - net width nn = `VC_NET_MSG_NBITS(mn,no,ns)`.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sd  in  1  security-domain label {L}; all message ports and counters are {Domain sd}.
- in_val  in  1  network message valid.
- in_rdy  out  1  adapter can accept a message.
- in_msg  in  nn  network message {dest, src, opaque, payload}, with payload in the LSBs.
- out_val  out  1  memory message valid.
- out_rdy  in  1  downstream accepts.
- out_msg  out  mn  unpacked memory message.
- misroute  out  1  sticky flag: a message with dest != p_net_dest was accepted.
- misroute_count  out  8  saturating count of misrouted messages.
- msg_count  out  16  wrapping count of messages dequeued on the output port.

## Operation
- Enqueue occurs when in_val && in_rdy; dequeue occurs when out_val && out_rdy.
- Transform applied at enqueue:
  - Extract payload = in_msg[mn-1:0].
  - p_is_resp=0: the payload is stored unchanged. The high ns opaque bits carry the requesting core id, which the bank needs to route the response.
  - p_is_resp=1: the opaque field is rewritten with its top ns bits cleared and the low mo-ns bits kept. The message is repacked via `vc_MemRespMsgPack`; type, len and data are unchanged.
  - Network src and opaque are discarded.
- Dest check at enqueue: if in_msg dest field != p_net_dest[ns-1:0]:
  - misroute is set to 1 and stays set until reset.
  - misroute_count increments and saturates at 8'hFF.
  - The message is still enqueued and delivered; it is never dropped.
- Queue: 2 entries, circular, with a 1-bit enq pointer, a 1-bit deq pointer and a 2-bit count.
  - States are EMPTY (count 0), ONE (count 1) and FULL (count 2).
  - EMPTY -> ONE on enqueue.
  - ONE -> FULL on enqueue without dequeue.
  - ONE -> EMPTY on dequeue without enqueue.
  - ONE stays ONE on simultaneous enqueue and dequeue; both pointers advance.
  - FULL -> ONE on dequeue.
- Signal rules:
  - in_rdy = (count != 2). There is no enqueue-through-full: in_rdy is 0 when FULL even if out_rdy=1.
  - out_val = (count != 0). out_msg = entry[deq_ptr] and is driven from storage only; there is no bypass.
  - Pointers wrap 1 -> 0.
- msg_count increments by 1 on each dequeue and wraps from 16'hFFFF to 0.

## Timing
- Latency: a message enqueued in cycle t is first visible on out_val/out_msg in cycle t+1.
- Throughput: 1 message per cycle sustained while out_rdy=1.
- in_rdy and out_val depend only on registered state. There are no combinational paths from in_val to out_val or from out_rdy to in_rdy.
- Values after reset, at the first edge with reset=1:
  - count=0, both pointers=0.
  - in_rdy=1, out_val=0, misroute=0, misroute_count=0, msg_count=0.
  - Entry storage is not reset. out_msg is don't-care while out_val=0.
- Reset asserted mid-operation discards all queued messages and counters at that edge. An enqueue or dequeue handshake in the reset cycle has no effect.
- out_msg must be held stable while out_val=1 && out_rdy=0.

## Test plan
- Basic resp (p_is_resp=1, mo=8, ns=3, p_net_dest=2):
  - Stimulus: one message with dest=2, src=1, opaque field 8'hA5, data 32'hDEADBEEF.
  - Required: in cycle t+1, out_val=1 and out_msg opaque=8'h05, with data, type and len unchanged. msg_count=1 after the dequeue.
- Req passthrough (p_is_resp=0):
  - Stimulus: a request with opaque 8'hE3 and addr 32'h0000_0040.
  - Required: out_msg is bit-identical to in_msg[mn-1:0].
- Backpressure and full:
  - Stimulus: out_rdy=0; enqueue 3 back-to-back messages.
  - Required: the first two are accepted and in_rdy=0 afterwards; the third is held. After raising out_rdy, the messages emerge in order, one per cycle, and out_msg is stable while stalled.
- Simultaneous enqueue and dequeue in ONE:
  - Stimulus: 10 streamed messages with in_val=out_rdy=1.
  - Required: count stays at 1, no bubbles, in-order output, msg_count=10.
- Misroute:
  - Stimulus: 3 messages with dest=5 while p_net_dest=2.
  - Required: misroute=1, misroute_count=3, and all 3 messages are delivered. With 300 misroutes, misroute_count stays at 8'hFF.
- Reset mid-operation:
  - Stimulus: queue FULL with misroute set; assert reset for 1 cycle.
  - Required: next cycle out_val=0, in_rdy=1, misroute=0, and both counters are 0.
